// File: rtl/systolic_drain.sv
// De-skews the systolic array's diagonal result stream into a row buffer
// and hands the tile out one row per valid/ready transfer.
module systolic_drain #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] col_in,
    output logic             busy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             start_err
);

    localparam int LAST = WIDTH + DEPTH - 2;
    localparam int CW   = $clog2(WIDTH + DEPTH);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             cap_en;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    ptr;
    logic [WIDTH-1:0] row_buf [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cap_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    cap_en   = 1'b1;
                    state_nx = (LAST == 0) ? DRAIN : CAPTURE;
                end
            end
            CAPTURE: begin
                cap_en = 1'b1;
                if (cnt == CW'(LAST)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready && ptr == PW'(DEPTH - 1)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // cnt is 0 in IDLE, so the start cycle itself is capture cycle c=0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cap_en && state_nx == CAPTURE) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (state != DRAIN) begin
            ptr <= '0;
        end else if (out_ready) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

    // Column j carries row r at capture cycle r+j; everything else is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                row_buf[r] <= '0;
            end
        end else if (cap_en) begin
            for (int r = 0; r < DEPTH; r++) begin
                for (int j = 0; j < WIDTH; j++) begin
                    if (cnt == CW'(r + j)) begin
                        row_buf[r][j] <= col_in[j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_err <= 1'b0;
        end else begin
            start_err <= start && (state != IDLE);
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == DRAIN);
    assign out_data  = out_valid ? row_buf[ptr] : '0;

endmodule

// File: tb/tb_systolic_drain.sv
// Randomised bench for systolic_drain: a tile model generates the skewed
// stream and the expected rows; each scenario checks its own results.
module tb_systolic_drain;

    typedef logic [7:0] tile_t [8];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] col_in = '0;
    logic       busy;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       start_err;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  got_q [$];
    int          stall_bad;
    int          drain_cyc;
    logic [31:0] err_mask;
    logic [31:0] vld_mask;

    systolic_drain #(.WIDTH(8), .DEPTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .col_in(col_in),
        .busy(busy),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .start_err(start_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Element (row r, column j) of the tile appears on col_in[j] at cycle r+j
    function automatic logic [7:0] skew(tile_t t, int c, bit noise);
        logic [7:0] v;
        for (int j = 0; j < 8; j++) begin
            if (c - j >= 0 && c - j < 8) v[j] = t[c-j][j];
            else v[j] = noise ? 1'($urandom) : 1'b0;
        end
        return v;
    endfunction

    function automatic tile_t rand_tile();
        tile_t t;
        for (int r = 0; r < 8; r++) t[r] = 8'($urandom);
        return t;
    endfunction

    // Drives one tile starting now (cycle T); returns in cycle T+15
    task automatic capture(input tile_t t, input bit noise, input int bs);
        err_mask = '0;
        vld_mask = '0;
        for (int c = 0; c <= 14; c++) begin
            start = (c == 0) || (c == bs);
            col_in = skew(t, c, noise);
            step();
            if (start_err) err_mask[c+1] = 1'b1;
            if (out_valid) vld_mask[c+1] = 1'b1;
        end
        start = 1'b0;
        col_in = noise ? 8'($urandom) : 8'h00;
    endtask

    // pat 0: ready always; pat 1: ready 1,0,0,...
    task automatic drain(input int pat, input bit fin_start);
        bit         prev_stall;
        logic [7:0] prev_data;
        got_q.delete();
        stall_bad = 0;
        drain_cyc = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int k = 0; k < 80 && got_q.size() < 8; k++) begin
            out_ready = (pat == 0) ? 1'b1 : (k % 3 == 0);
            col_in = 8'($urandom);
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data))
                stall_bad++;
            start = fin_start && out_valid && out_ready && got_q.size() == 7;
            if (out_valid && out_ready) got_q.push_back(out_data);
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            step();
            drain_cyc++;
            start = 1'b0;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({busy, out_valid, out_data, start_err} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b valid=%b data=%h err=%b expected all 0",
                     busy, out_valid, out_data, start_err);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b valid=%b expected 0 0", busy, out_valid);
        end
    endtask

    task automatic test_identity();
        tile_t t;
        for (int r = 0; r < 8; r++) t[r] = 8'h01 << r;
        capture(t, 1'b0, -1);
        n_checks++;
        if (vld_mask !== 32'h8000) begin
            n_fail++;
            $display("FAIL ident_first_valid: got mask %h expected %h", vld_mask, 32'h8000);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ident_busy: got %b expected 1", busy);
        end
        drain(0, 1'b0);
        n_checks++;
        if (got_q.size() !== 8) begin
            n_fail++;
            $display("FAIL ident_count: got %0d expected 8", got_q.size());
        end
        for (int r = 0; r < 8; r++) begin
            n_checks++;
            if (got_q[r] !== t[r]) begin
                n_fail++;
                $display("FAIL ident_row%0d: got %h expected %h", r, got_q[r], t[r]);
            end
        end
        n_checks++;
        if (drain_cyc !== 8 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ident_end: got cyc=%0d busy=%b valid=%b expected 8 0 0",
                     drain_cyc, busy, out_valid);
        end
    endtask

    task automatic test_distinct();
        tile_t t;
        for (int r = 0; r < 8; r++) t[r] = 8'hA5 ^ 8'(r);
        capture(t, 1'b1, -1);
        drain(0, 1'b0);
        n_checks++;
        if (got_q.size() !== 8) begin
            n_fail++;
            $display("FAIL dist_count: got %0d expected 8", got_q.size());
        end
        for (int r = 0; r < 8; r++) begin
            n_checks++;
            if (got_q[r] !== t[r]) begin
                n_fail++;
                $display("FAIL dist_row%0d: got %h expected %h", r, got_q[r], t[r]);
            end
        end
    endtask

    task automatic test_random_tiles();
        for (int n = 0; n < 4; n++) begin
            tile_t t;
            t = rand_tile();
            capture(t, 1'b1, -1);
            drain(0, 1'b0);
            for (int r = 0; r < 8; r++) begin
                n_checks++;
                if (got_q[r] !== t[r]) begin
                    n_fail++;
                    $display("FAIL rand%0d_row%0d: got %h expected %h", n, r, got_q[r], t[r]);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        tile_t t;
        t = rand_tile();
        capture(t, 1'b1, -1);
        drain(1, 1'b0);
        n_checks++;
        if (stall_bad !== 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d changes expected 0", stall_bad);
        end
        n_checks++;
        if (got_q.size() !== 8 || drain_cyc !== 22) begin
            n_fail++;
            $display("FAIL bp_count: got rows=%0d cyc=%0d expected 8 22", got_q.size(), drain_cyc);
        end
        for (int r = 0; r < 8; r++) begin
            n_checks++;
            if (got_q[r] !== t[r]) begin
                n_fail++;
                $display("FAIL bp_row%0d: got %h expected %h", r, got_q[r], t[r]);
            end
        end
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: got valid=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_busy_start();
        tile_t t;
        t = rand_tile();
        capture(t, 1'b1, 5);
        n_checks++;
        if (err_mask !== 32'h40) begin
            n_fail++;
            $display("FAIL busy_err_capture: got mask %h expected %h", err_mask, 32'h40);
        end
        drain(0, 1'b1);
        for (int r = 0; r < 8; r++) begin
            n_checks++;
            if (got_q[r] !== t[r]) begin
                n_fail++;
                $display("FAIL busy_row%0d: got %h expected %h", r, got_q[r], t[r]);
            end
        end
        n_checks++;
        if (start_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_err_final: got err=%b busy=%b expected 1 0", start_err, busy);
        end
        step();
        n_checks++;
        if (start_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_err_clear: got err=%b busy=%b expected 0 0", start_err, busy);
        end
    endtask

    task automatic test_reset_mid();
        tile_t t;
        tile_t ff;
        t = rand_tile();
        for (int r = 0; r < 8; r++) ff[r] = 8'hFF;
        capture(t, 1'b1, -1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, out_valid, out_data, start_err} !== 11'h0) begin
            n_fail++;
            $display("FAIL rst_mid: got busy=%b valid=%b data=%h err=%b expected all 0",
                     busy, out_valid, out_data, start_err);
        end
        step();
        rst = 1'b0;
        step();
        capture(ff, 1'b1, -1);
        drain(0, 1'b0);
        n_checks++;
        if (got_q.size() !== 8) begin
            n_fail++;
            $display("FAIL rst_new_count: got %0d expected 8", got_q.size());
        end
        for (int r = 0; r < 8; r++) begin
            n_checks++;
            if (got_q[r] !== 8'hFF) begin
                n_fail++;
                $display("FAIL rst_new_row%0d: got %h expected ff", r, got_q[r]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_leftover: got valid=%b expected 0", out_valid);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        tile_t a;
        tile_t b;
        a = rand_tile();
        b = rand_tile();
        capture(a, 1'b1, -1);
        drain(0, 1'b0);
        capture(b, 1'b1, -1);
        n_checks++;
        if (err_mask !== 32'h0) begin
            n_fail++;
            $display("FAIL b2b_err: got mask %h expected 0", err_mask);
        end
        n_checks++;
        if (vld_mask !== 32'h8000) begin
            n_fail++;
            $display("FAIL b2b_first_valid: got mask %h expected %h", vld_mask, 32'h8000);
        end
        drain(0, 1'b0);
        for (int r = 0; r < 8; r++) begin
            n_checks++;
            if (got_q[r] !== b[r]) begin
                n_fail++;
                $display("FAIL b2b_row%0d: got %h expected %h", r, got_q[r], b[r]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_distinct();
        test_random_tiles();
        test_backpressure();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_drain.md
# systolic_drain

Output-side collector for the 8x8 1-bit systolic array. The array emits its result tile skewed: column j lags column 0 by j cycles. This block de-skews that stream into a WIDTH x DEPTH row buffer. It then presents the tile one row per transfer on a valid/ready port toward the chip outputs (uo_out).

## Interface

Parameters:
- WIDTH, 8, number of array columns = bits per output row
- DEPTH, 8, number of rows per result tile

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high; clears all state
- start  input  1  one-cycle pulse: row 0 / column 0 of a tile is on col_in[0] in this cycle
- col_in  input  WIDTH  skewed array output; bit j = column j
- busy  output  1  high whenever state != IDLE
- out_data  output  WIDTH  current output row, bit j = column j
- out_valid  output  1  out_data holds a valid row
- out_ready  input  1  consumer accepts the row when out_valid && out_ready
- start_err  output  1  one-cycle pulse: start arrived while busy (start ignored)

## Operation

- States: IDLE, CAPTURE, DRAIN. Reset enters IDLE.
- Reset values: busy=0, out_valid=0, out_data=0, start_err=0; buffer, cycle counter and row pointer all 0.
- IDLE, start=1:
  - enter CAPTURE with capture counter c=0.
  - col_in is sampled in this same cycle as c=0.
- CAPTURE, cycle c (0..WIDTH+DEPTH-2):
  - for every column j, if 0 <= c-j < DEPTH, write buf[c-j][j] = col_in[j].
  - bits outside that window are discarded.
  - the final value c = WIDTH+DEPTH-2 (14 at defaults) writes buf[DEPTH-1][WIDTH-1]; the next state is DRAIN, row pointer = 0.
- DRAIN:
  - out_valid=1 and out_data=buf[row pointer].
  - on handshake (out_valid && out_ready) the row pointer increments.
  - the handshake on row DEPTH-1 returns the block to IDLE; out_valid drops to 0 in the next cycle.
- out_data and out_valid must not change while out_valid=1 and out_ready=0.
- start while busy=1:
  - ignored; no effect on the capture or drain in progress.
  - start_err pulses high in the following cycle.
  - this includes the cycle of the final DRAIN handshake, because busy is still 1 then.
- start in IDLE does not clear the buffer. Every buffer bit is overwritten during CAPTURE.
- rst asserted at any point (mid-CAPTURE, mid-DRAIN):
  - all outputs and state return to reset values immediately.
  - the partial tile is lost.
  - the first start after rst deasserts is accepted normally.
- Unused col_in bits in IDLE and DRAIN are don't-care and must not alter the buffer.

## Timing

- Let T be the start cycle.
- CAPTURE occupies cycles T .. T+WIDTH+DEPTH-2 (T..T+14 at defaults).
- busy rises in cycle T+1 (registered) and stays high until the cycle after the final handshake.
- First out_valid=1 in cycle T+WIDTH+DEPTH-1 (T+15).
- With out_ready held high, rows 0..DEPTH-1 are transferred in cycles T+15..T+22.
- busy=0 and out_valid=0 in cycle T+23; the earliest accepted next start is T+23.
- Throughput: one row per cycle in DRAIN when out_ready=1; no bubbles between rows.
- start_err is registered and appears one cycle after the offending start.

## Test plan

- Identity tile:
  - stimulus: start at T; col_in[j]=1 exactly when c=2j, else 0.
  - required: out_data rows 0x01,0x02,0x04,...,0x80 in order, first at T+15; busy=0 at T+23.
- Distinct rows:
  - stimulus: tile R[r]=0xA5 ^ r, driven with correct skew (col_in[j]=R[c-j][j]).
  - required: exactly R[0..7] emitted; out-of-window col_in bits are randomised and must not corrupt the result.
- Backpressure:
  - stimulus: out_ready toggled 1,0,0,1,... during DRAIN.
  - required: out_data/out_valid stable while stalled; 8 rows total, no duplicates or drops.
- Busy start:
  - stimulus: start pulsed at T+5 (CAPTURE) and in the cycle of the final handshake.
  - required: start_err pulses one cycle later each time; the current tile is emitted unchanged.
- Reset mid-operation:
  - stimulus: rst high during DRAIN after row 3, then released, then a new tile of all 0xFF rows.
  - required: outputs 0 immediately on rst; the new tile yields eight rows of 0xFF with no leftover rows.
- Back-to-back tiles:
  - stimulus: second start at exactly T+23.
  - required: accepted (no start_err); second tile's first row valid at T+38.
